regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (w_en/w_addr/w_data) between two writeback

---
 rtl/rv_pkg.sv | 30 +++
 rtl/regfile_wb_arbiter_fifo.sv | 68 ++++++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_pkg : shared widths and types for the regfile writeback path     |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AREG = 5;
  localparam int TAGW = 3;
  localparam int NREG = 1 << AREG;

  typedef enum logic [0:0] {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [AREG-1:0] addr;
    logic [XLEN-1:0] data;
    logic [TAGW-1:0] tag;
  } wb_entry_t;

  function automatic logic [NREG-1:0] addr_onehot(input logic [AREG-1:0] a);
    return {{(NREG-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_fifo : DEPTH-entry writeback queue with per-entry valid bits     |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  wb_entry_t       i_entry,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output logic            o_valid,
  output logic            o_full,
  output logic [NREG-1:0] o_occ
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [DEPTH-1:0] r_vld;
  wb_entry_t        r_mem [DEPTH];

  // Push is applied after pop so a same-slot push/pop leaves the slot valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_vld <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_rd] <= 1'b0;
        r_rd        <= r_rd + 1'b1;
      end
      if (i_push) begin
        r_vld[r_wr] <= 1'b1;
        r_wr        <= r_wr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr] <= i_entry;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_valid = r_vld[r_rd];
  assign o_full  = &r_vld;

  always_comb begin
    o_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) begin
        o_occ = o_occ | addr_onehot(r_mem[i].addr);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_wb_arbiter : age-ordered sharing of the regfile write port  |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AREG-1:0] alu_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AREG-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            w_en,
  output logic [AREG-1:0] w_addr,
  output logic [XLEN-1:0] w_data,
  output logic [NREG-1:0] busy_mask
);

  logic [TAGW-1:0] r_tag;
  wb_src_e         r_rr;

  logic            w_alu_full, w_lsu_full;
  logic            w_alu_hv,   w_lsu_hv;
  logic            w_alu_push, w_lsu_push;
  wb_entry_t       w_alu_in,   w_lsu_in;
  wb_entry_t       w_alu_head, w_lsu_head;
  logic [NREG-1:0] w_alu_occ,  w_lsu_occ;
  logic [TAGW-1:0] w_age;
  logic            w_gnt_alu, w_gnt_lsu, w_tie;
  wb_entry_t       w_sel;

  assign alu_ready = !rst && !w_alu_full;
  assign lsu_ready = !rst && !w_lsu_full;

  // Writes to x0 complete the handshake but are dropped here.
  assign w_alu_push = alu_valid && alu_ready && (alu_addr != '0);
  assign w_lsu_push = lsu_valid && lsu_ready && (lsu_addr != '0);
  assign w_alu_in   = {alu_addr, alu_data, r_tag};
  assign w_lsu_in   = {lsu_addr, lsu_data, r_tag};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_alu_push),
    .i_entry (w_alu_in),
    .i_pop   (w_gnt_alu),
    .o_head  (w_alu_head),
    .o_valid (w_alu_hv),
    .o_full  (w_alu_full),
    .o_occ   (w_alu_occ)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_lsu_push),
    .i_entry (w_lsu_in),
    .i_pop   (w_gnt_lsu),
    .o_head  (w_lsu_head),
    .o_valid (w_lsu_hv),
    .o_full  (w_lsu_full),
    .o_occ   (w_lsu_occ)
  );

  // Tags live within a short window, so a negative modular difference means ALU is older.
  assign w_age = w_alu_head.tag - w_lsu_head.tag;

  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    w_tie     = 1'b0;
    if (w_alu_hv && w_lsu_hv) begin
      if (w_age == '0) begin
        w_tie     = 1'b1;
        w_gnt_alu = (r_rr == WB_ALU);
      end else begin
        w_gnt_alu = w_age[TAGW-1];
      end
      w_gnt_lsu = !w_gnt_alu;
    end else begin
      w_gnt_alu = w_alu_hv;
      w_gnt_lsu = w_lsu_hv;
    end
  end

  assign w_sel = w_gnt_alu ? w_alu_head : w_lsu_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag  <= '0;
      r_rr   <= WB_ALU;
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      r_tag <= r_tag + 1'b1;
      w_en  <= w_gnt_alu || w_gnt_lsu;
      if (w_gnt_alu || w_gnt_lsu) begin
        w_addr <= w_sel.addr;
        w_data <= w_sel.data;
      end
      if (w_tie) begin
        r_rr <= w_gnt_alu ? WB_LSU : WB_ALU;
      end
    end
  end

  assign busy_mask = (w_alu_occ | w_lsu_occ | (w_en ? addr_onehot(w_addr) : '0))
                   & {{(NREG-1){1'b1}}, 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : directed vector bench for the WB arbiter    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_addr, lsu_addr, w_addr;
  logic [31:0] alu_data, lsu_data, w_data, busy_mask;
  logic        w_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy_mask (busy_mask)
  );

  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ear;
    logic        elr;
    logic        ewen;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  localparam int NV = 32;
  vec_t tbl [NV];
  wr_t  exp_q [$];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic lv, input logic [4:0] la,
                              input logic [31:0] ld, input logic ear, input logic elr,
                              input logic ewen, input logic [4:0] ewa, input logic [31:0] ewd,
                              input logic [31:0] ebusy);
    vec_t v;
    v.r = r; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.ear = ear; v.elr = elr; v.ewen = ewen; v.ewa = ewa; v.ewd = ewd; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic check_w(input int idx);
    wr_t e;
    if (w_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t7_extra_write [%0d]: actual=%h required=none", idx, w_addr);
      end else begin
        e = exp_q.pop_front();
        chk("t7_addr", idx, 32'(w_addr), 32'(e.a));
        chk("t7_data", idx, w_data, e.d);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic a_acc, l_acc;
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;

    //              r  av aa  ad           lv la  ld           ar lr wen wa  wd           busy
    tbl[0]  = mk(1, 0, 0,  32'h0,      0, 0,  32'h0,      0, 0, 0, 0,  32'h0,      32'h0);
    tbl[1]  = mk(1, 0, 0,  32'h0,      0, 0,  32'h0,      0, 0, 0, 0,  32'h0,      32'h0);
    tbl[2]  = mk(0, 1, 5,  32'hDEAD,   0, 0,  32'h0,      1, 1, 0, 0,  32'h0,      32'h20);
    tbl[3]  = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 5,  32'hDEAD,   32'h20);
    tbl[4]  = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 5,  32'hDEAD,   32'h0);
    tbl[5]  = mk(0, 1, 3,  32'h111,    0, 0,  32'h0,      1, 1, 0, 5,  32'hDEAD,   32'h8);
    tbl[6]  = mk(0, 0, 0,  32'h0,      1, 3,  32'h2,      1, 1, 1, 3,  32'h111,    32'h8);
    tbl[7]  = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 3,  32'h2,      32'h8);
    tbl[8]  = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 3,  32'h2,      32'h0);
    tbl[9]  = mk(0, 1, 1,  32'hA1,     1, 2,  32'hB2,     1, 1, 0, 3,  32'h2,      32'h6);
    tbl[10] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 1,  32'hA1,     32'h6);
    tbl[11] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 2,  32'hB2,     32'h4);
    tbl[12] = mk(0, 1, 1,  32'hA3,     1, 2,  32'hB4,     1, 1, 0, 2,  32'hB2,     32'h6);
    tbl[13] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 2,  32'hB4,     32'h6);
    tbl[14] = mk(0, 1, 1,  32'hA5,     1, 2,  32'hB6,     1, 1, 1, 1,  32'hA3,     32'h6);
    tbl[15] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 1,  32'hA5,     32'h6);
    tbl[16] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 2,  32'hB6,     32'h4);
    tbl[17] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 2,  32'hB6,     32'h0);
    tbl[18] = mk(0, 1, 0,  32'hFFFF,   0, 0,  32'h0,      1, 1, 0, 2,  32'hB6,     32'h0);
    tbl[19] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 2,  32'hB6,     32'h0);
    tbl[20] = mk(0, 1, 7,  32'h70,     1, 8,  32'h80,     1, 1, 0, 2,  32'hB6,     32'h180);
    tbl[21] = mk(0, 1, 9,  32'h90,     1, 10, 32'hA0,     1, 1, 1, 8,  32'h80,     32'h780);
    tbl[22] = mk(1, 0, 0,  32'h0,      0, 0,  32'h0,      0, 0, 0, 0,  32'h0,      32'h0);
    tbl[23] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 0,  32'h0,      32'h0);
    tbl[24] = mk(0, 1, 11, 32'hB1,     1, 12, 32'hC1,     1, 1, 0, 0,  32'h0,      32'h1800);
    tbl[25] = mk(0, 1, 13, 32'hB2,     1, 14, 32'hC2,     1, 1, 1, 11, 32'hB1,     32'h7800);
    tbl[26] = mk(0, 0, 0,  32'h0,      1, 15, 32'hC3,     1, 0, 1, 12, 32'hC1,     32'h7000);
    tbl[27] = mk(0, 0, 0,  32'h0,      1, 15, 32'hC3,     1, 1, 1, 14, 32'hC2,     32'hE000);
    tbl[28] = mk(0, 0, 0,  32'h0,      1, 16, 32'hC4,     1, 1, 1, 13, 32'hB2,     32'h1A000);
    tbl[29] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 0, 1, 15, 32'hC3,     32'h18000);
    tbl[30] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 1, 16, 32'hC4,     32'h10000);
    tbl[31] = mk(0, 0, 0,  32'h0,      0, 0,  32'h0,      1, 1, 0, 16, 32'hC4,     32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      rst       = tbl[i].r;
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_addr = tbl[i].la; lsu_data = tbl[i].ld;
      #1;
      chk("alu_ready", i, 32'(alu_ready), 32'(tbl[i].ear));
      chk("lsu_ready", i, 32'(lsu_ready), 32'(tbl[i].elr));
      @(posedge clk);
      #1;
      chk("w_en",      i, 32'(w_en),      32'(tbl[i].ewen));
      chk("w_addr",    i, 32'(w_addr),    32'(tbl[i].ewa));
      chk("w_data",    i, w_data,         tbl[i].ewd);
      chk("busy_mask", i, busy_mask,      tbl[i].ebusy);
    end

    // Continuous traffic across several tag wraps; writes must leave in acceptance order.
    alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) begin
        alu_valid = 1'b1; alu_addr = 5'd17; alu_data = 32'h5A00_0000;
        lsu_valid = 1'b1; lsu_addr = 5'd18; lsu_data = 32'h5B00_0000;
      end else if (c <= 20 && !alu_valid && !lsu_valid) begin
        if (c % 2 == 1) begin
          lsu_valid = 1'b1; lsu_addr = 5'(c % 31 + 1); lsu_data = 32'h7B00_0000 + 32'(c);
        end else begin
          alu_valid = 1'b1; alu_addr = 5'(c % 31 + 1); alu_data = 32'h7A00_0000 + 32'(c);
        end
      end
      #1;
      a_acc = alu_valid && alu_ready;
      l_acc = lsu_valid && lsu_ready;
      if (a_acc) exp_q.push_back('{a: alu_addr, d: alu_data});
      if (l_acc) exp_q.push_back('{a: lsu_addr, d: lsu_data});
      @(posedge clk);
      #1;
      if (a_acc) alu_valid = 1'b0;
      if (l_acc) lsu_valid = 1'b0;
      check_w(c);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check_w(100 + k);
    end
    chk("t7_drained", 0, 32'(exp_q.size()), 32'd0);
    chk("t7_idle_busy", 0, busy_mask, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
